biriscv_fetch_queue: RTL

- Instruction buffer between the fetch unit and decode.
- Accepts fetched packets (PC, 32-bit instruction word, fetch-fault flag) into a DEPTH-entry FIFO.
- The head entry drives the decode stage: dec_valid_o feeds biriscv_decoder valid_i, dec_instr_o feeds opcode_i, and dec_fault_o feeds fetch_fault_i.
- Decouples fetch from issue stalls, squashes all entries on pipeline flush, and blocks further fetch after a faulting packet until redirect.

---
 rtl/biriscv_fetch_queue.sv | 73 +++++++
 1 files changed

// File: rtl/biriscv_fetch_queue.sv
// Instruction buffer between fetch and decode.
// Count-based FIFO with flush squash and a fetch block after a faulting packet.
module biriscv_fetch_queue #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fetch_valid_i,
    input  logic [31:0]      fetch_pc_i,
    input  logic [31:0]      fetch_instr_i,
    input  logic             fetch_fault_i,
    output logic             fetch_accept_o,
    input  logic             flush_i,
    output logic             dec_valid_o,
    output logic [31:0]      dec_pc_o,
    output logic [31:0]      dec_instr_o,
    output logic             dec_fault_o,
    input  logic             dec_accept_i,
    output logic [PTR_W:0]   level_o
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [64:0]      mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             fault_pending_q;
    logic             push;
    logic             pop;

    // Accept depends on registered state only, never on flush or dec_accept
    assign fetch_accept_o = !rst_i && (count != FULL) && !fault_pending_q;
    assign dec_valid_o    = (count != '0) && !flush_i;
    assign push           = fetch_valid_i && fetch_accept_o && !flush_i;
    assign pop            = dec_valid_o && dec_accept_i;
    assign level_o        = count;

    assign {dec_fault_o, dec_pc_o, dec_instr_o} = mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            fault_pending_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            fault_pending_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && fetch_fault_i)
                fault_pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr] <= {fetch_fault_i, fetch_pc_i, fetch_instr_i};
    end

endmodule
